// File: rtl/v_latch_gate_ctrl.sv
// v_latch_gate_ctrl: registered G/D/CLR sequencer for a transparent-latch bank with setup/gate/hold margins
module v_latch_gate_ctrl #(
    parameter int DWIDTH    = 8,
    parameter int SETUP_CYC = 1,
    parameter int GATE_CYC  = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CLR_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              clr_req,
    output logic              g,
    output logic [DWIDTH-1:0] d,
    output logic              clr,
    output logic              busy,
    output logic              done
);
    localparam int M1 = SETUP_CYC > GATE_CYC ? SETUP_CYC : GATE_CYC;
    localparam int M2 = HOLD_CYC > CLR_CYC ? HOLD_CYC : CLR_CYC;
    localparam int MX = M1 > M2 ? M1 : M2;
    localparam int CW = MX > 1 ? $clog2(MX) : 1;
    typedef enum logic [2:0] {CLEAR, IDLE, SETUP, GATE, HOLD} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic pend, ready_q, last;
    assign last = (cnt == '0);
    // ready_q also rises for the final HOLD cycle so a new write can be accepted on the HOLD exit edge
    assign wr_ready = ready_q & ~clr_req & ~pend;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            cnt     <= CW'(CLR_CYC - 1);
            clr     <= 1'b1;
            g       <= 1'b0;
            d       <= '0;
            ready_q <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pend    <= 1'b0;
        end else begin
            done <= 1'b0;
            cnt  <= last ? cnt : cnt - 1'b1;
            if (state inside {SETUP, GATE, HOLD}) pend <= pend | clr_req;
            case (state)
                CLEAR: if (last) begin
                    state   <= IDLE;
                    clr     <= 1'b0;
                    ready_q <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                IDLE: if (clr_req) begin
                    state   <= CLEAR;
                    cnt     <= CW'(CLR_CYC - 1);
                    clr     <= 1'b1;
                    ready_q <= 1'b0;
                    busy    <= 1'b1;
                end else if (wr_valid) begin
                    state   <= SETUP;
                    cnt     <= CW'(SETUP_CYC - 1);
                    d       <= wr_data;
                    ready_q <= 1'b0;
                    busy    <= 1'b1;
                end
                SETUP: if (last) begin
                    state <= GATE;
                    cnt   <= CW'(GATE_CYC - 1);
                    g     <= 1'b1;
                end
                GATE: if (last) begin
                    state   <= HOLD;
                    cnt     <= CW'(HOLD_CYC - 1);
                    g       <= 1'b0;
                    ready_q <= (HOLD_CYC == 1);
                end
                HOLD: if (!last) ready_q <= (cnt == CW'(1));
                else begin
                    done <= 1'b1;
                    if (wr_valid && wr_ready) begin
                        state   <= SETUP;
                        cnt     <= CW'(SETUP_CYC - 1);
                        d       <= wr_data;
                        ready_q <= 1'b0;
                    end else if (pend || clr_req) begin
                        state   <= CLEAR;
                        cnt     <= CW'(CLR_CYC - 1);
                        clr     <= 1'b1;
                        pend    <= 1'b0;
                        ready_q <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_v_latch_gate_ctrl.sv
// tb_v_latch_gate_ctrl: directed checks of reset, write timing, back-to-back, clear merging and async reset
module tb_v_latch_gate_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, wr_valid = 1'b0, clr_req = 1'b0;
    logic [7:0] wr_data = '0;
    logic wr_ready, g, clr, busy, done;
    logic [7:0] d;
    int chk_cnt = 0, pass_cnt = 0;
    logic pg = 1'b0;
    logic [7:0] pd = '0;

    always #5 clk = ~clk;

    v_latch_gate_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .clr_req(clr_req), .g(g), .d(d), .clr(clr), .busy(busy), .done(done)
    );

    always @(negedge clk) begin
        chk_cnt++;
        if ((g & clr) !== 1'b0) $display("FAIL overlap: g=%b clr=%b, required not both high", g, clr);
        else pass_cnt++;
        if (pg && g) begin
            chk_cnt++;
            if (d !== pd) $display("FAIL d_stable_gate: d=%h, required %h", d, pd);
            else pass_cnt++;
        end
        pg = g;
        pd = d;
    end

    task automatic test_reset;
        rst_n = 1'b0; wr_valid = 1'b0; clr_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({clr, g, busy, wr_ready, done, d} !== {5'b10100, 8'h00})
            $display("FAIL reset_vals: clr,g,busy,rdy,done,d=%b%b%b%b%b %h, required 10100 00", clr, g, busy, wr_ready, done, d);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({clr, busy, wr_ready} !== 3'b110) $display("FAIL reset_clr1: clr,busy,rdy=%b%b%b, required 110", clr, busy, wr_ready);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({clr, wr_ready, g, busy, done, d} !== {5'b01001, 8'h00})
            $display("FAIL reset_idle: clr,rdy,g,busy,done,d=%b%b%b%b%b %h, required 01001 00", clr, wr_ready, g, busy, done, d);
        else pass_cnt++;
    endtask

    task automatic test_single_write;
        logic [4:0] eg = 5'b00110, er = 5'b11000, ed = 5'b10000, eb = 5'b01111;
        chk_cnt++;
        if (wr_ready !== 1'b1) $display("FAIL sw_ready_pre: wr_ready=%b, required 1", wr_ready);
        else pass_cnt++;
        wr_data = 8'hA5; wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0; wr_data = 8'h00;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            chk_cnt++;
            if ({g, wr_ready, done, busy, d} !== {eg[j], er[j], ed[j], eb[j], 8'hA5})
                $display("FAIL sw_cycle%0d: g,rdy,done,busy,d=%b%b%b%b %h, required %b%b%b%b a5",
                         j, g, wr_ready, done, busy, d, eg[j], er[j], ed[j], eb[j]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        int acc[2];
        int n = 0;
        wr_data = 8'hA5; wr_valid = 1'b1;
        for (int c = 0; c < 20 && n < 2; c++) begin
            if (wr_ready) begin acc[n] = c; n++; end
            @(negedge clk);
            if (n == 1) wr_data = 8'h3C;
            if (n == 2) wr_valid = 1'b0;
        end
        wr_valid = 1'b0;
        chk_cnt++;
        if (n !== 2) $display("FAIL b2b_accepts: got %0d acceptances, required 2", n);
        else pass_cnt++;
        chk_cnt++;
        if (n == 2 && acc[1] - acc[0] == 4) pass_cnt++;
        else $display("FAIL b2b_spacing: %0d cycles, required 4", n == 2 ? acc[1] - acc[0] : -1);
        chk_cnt++;
        if (d !== 8'h3C) $display("FAIL b2b_data: d=%h, required 3c", d);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        chk_cnt++;
        if ({busy, wr_ready} !== 2'b01) $display("FAIL b2b_idle: busy,rdy=%b%b, required 01", busy, wr_ready);
        else pass_cnt++;
    endtask

    task automatic test_clear_during_write;
        logic [6:0] eg = 7'b0000110, ec = 7'b0110000, ed = 7'b1010000, er = 7'b1000000;
        int rises = 0;
        logic pc = 1'b0;
        wr_data = 8'hC3; wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int j = 0; j < 9; j++) begin
            if (j > 0) @(negedge clk);
            if (clr && !pc) rises++;
            pc = clr;
            if (j < 7) begin
                chk_cnt++;
                if ({g, clr, done, wr_ready, d} !== {eg[j], ec[j], ed[j], er[j], 8'hC3})
                    $display("FAIL cdw_cycle%0d: g,clr,done,rdy,d=%b%b%b%b %h, required %b%b%b%b c3",
                             j, g, clr, done, wr_ready, d, eg[j], ec[j], ed[j], er[j]);
                else pass_cnt++;
            end
            if (j == 1) clr_req = 1'b1;
            if (j == 2) clr_req = 1'b0;
        end
        chk_cnt++;
        if (rises !== 1) $display("FAIL cdw_clear_count: %0d clears, required 1", rises);
        else pass_cnt++;
    endtask

    task automatic test_clr_priority;
        clr_req = 1'b1; wr_valid = 1'b1; wr_data = 8'h77;
        #1;
        chk_cnt++;
        if (wr_ready !== 1'b0) $display("FAIL pri_ready: wr_ready=%b, required 0", wr_ready);
        else pass_cnt++;
        @(negedge clk);
        clr_req = 1'b0;
        chk_cnt++;
        if ({clr, busy, wr_ready, d} !== {3'b110, 8'hC3})
            $display("FAIL pri_clear1: clr,busy,rdy,d=%b%b%b %h, required 110 c3", clr, busy, wr_ready, d);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({clr, wr_ready} !== 2'b10) $display("FAIL pri_clear2: clr,rdy=%b%b, required 10", clr, wr_ready);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({clr, wr_ready, done} !== 3'b011) $display("FAIL pri_exit: clr,rdy,done=%b%b%b, required 011", clr, wr_ready, done);
        else pass_cnt++;
        @(negedge clk);
        wr_valid = 1'b0;
        chk_cnt++;
        if ({d, busy, wr_ready} !== {8'h77, 2'b10}) $display("FAIL pri_write: d,busy,rdy=%h %b%b, required 77 10", d, busy, wr_ready);
        else pass_cnt++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_gate;
        wr_data = 8'h5A; wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (g !== 1'b1) $display("FAIL rmg_gate: g=%b, required 1", g);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({g, clr, busy, wr_ready, d} !== {4'b0110, 8'h00})
            $display("FAIL rmg_async: g,clr,busy,rdy,d=%b%b%b%b %h, required 0110 00", g, clr, busy, wr_ready, d);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({clr, g} !== 2'b10) $display("FAIL rmg_clr: clr,g=%b%b, required 10", clr, g);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({clr, wr_ready, g, d} !== {3'b010, 8'h00}) $display("FAIL rmg_idle: clr,rdy,g,d=%b%b%b %h, required 010 00", clr, wr_ready, g, d);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_clear_during_write();
        test_clr_priority();
        test_reset_mid_gate();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
